// File: rtl/node_integrator.sv
// Circuit-node integrator: sums signed channel currents onto a clamped node voltage,
// derives a hysteretic logic level and reports when the node has stopped moving.
module node_integrator #(
  parameter int W             = 16,
  parameter int N             = 4,
  parameter int SHIFT         = 2,
  parameter int VHI           = 16384,
  parameter int VLO           = -16384,
  parameter int TH_HI         = 4096,
  parameter int TH_LO         = -4096,
  parameter int EPS           = 0,
  parameter int SETTLE_CYCLES = 8,
  parameter bit INIT_LOGIC    = 1'b0
) (
  input  logic                eclk,
  input  logic                erst_n,
  input  logic                en,
  input  logic                load,
  input  logic signed [W-1:0] load_v,
  input  logic [N*W-1:0]      i_flat,
  output logic signed [W-1:0] v,
  output logic                logic_o,
  output logic                settled,
  output logic                sat_flag
);

  // Sum width leaves no room for overflow; voltage path adds two more guard bits.
  localparam int SW = W + $clog2(N) + 1;
  localparam int VW = SW + 2;
  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  localparam logic signed [VW-1:0] VHI_X   = VW'(VHI);
  localparam logic signed [VW-1:0] VLO_X   = VW'(VLO);
  localparam logic signed [W-1:0]  VHI_W   = W'(VHI);
  localparam logic signed [W-1:0]  VLO_W   = W'(VLO);
  localparam logic signed [W-1:0]  TH_HI_W = W'(TH_HI);
  localparam logic signed [W-1:0]  TH_LO_W = W'(TH_LO);
  localparam logic [W:0]           EPS_X   = (W+1)'(EPS);
  localparam logic [CW-1:0]        CNT_MAX = CW'(SETTLE_CYCLES);

  logic signed [SW-1:0] sum;
  logic signed [SW-1:0] step;
  logic signed [VW-1:0] vn;
  logic signed [VW-1:0] lv_x;
  logic signed [W-1:0]  v_next;
  logic                 sat_next;
  logic                 logic_next;
  logic signed [W:0]    delta;
  logic [W:0]           abs_delta;
  logic                 quiet;
  logic [CW-1:0]        cnt;
  logic [CW-1:0]        cnt_next;

  always_comb begin
    sum = '0;
    for (int k = 0; k < N; k++) begin
      sum = sum + {{(SW-W){i_flat[k*W+W-1]}}, i_flat[k*W +: W]};
    end
  end

  assign step = sum >>> SHIFT;
  assign vn   = {{(VW-W){v[W-1]}}, v} + {{2{step[SW-1]}}, step};
  assign lv_x = {{(VW-W){load_v[W-1]}}, load_v};

  // Load takes priority; currents are ignored on a load cycle.
  always_comb begin
    logic signed [VW-1:0] raw;
    raw      = load ? lv_x : vn;
    sat_next = 1'b0;
    v_next   = raw[W-1:0];
    if (raw > VHI_X) begin
      v_next   = VHI_W;
      sat_next = 1'b1;
    end else if (raw < VLO_X) begin
      v_next   = VLO_W;
      sat_next = 1'b1;
    end
  end

  always_comb begin
    logic_next = logic_o;
    if (v_next > TH_HI_W)      logic_next = 1'b1;
    else if (v_next < TH_LO_W) logic_next = 1'b0;
  end

  assign delta     = {v_next[W-1], v_next} - {v[W-1], v};
  assign abs_delta = delta[W] ? unsigned'(-delta) : unsigned'(delta);
  assign quiet     = (abs_delta <= EPS_X);

  always_comb begin
    cnt_next = '0;
    if (quiet) cnt_next = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge eclk or negedge erst_n) begin
    if (!erst_n) begin
      v        <= INIT_LOGIC ? VHI_W : VLO_W;
      logic_o  <= INIT_LOGIC;
      settled  <= 1'b0;
      sat_flag <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      v        <= v_next;
      logic_o  <= logic_next;
      sat_flag <= sat_next;
      settled  <= 1'b0;
      cnt      <= '0;
    end else if (en) begin
      v        <= v_next;
      logic_o  <= logic_next;
      sat_flag <= sat_next;
      cnt      <= cnt_next;
      settled  <= (cnt_next == CNT_MAX);
    end
  end

endmodule

// File: doc/node_integrator.md
Name: node_integrator

Overview:
- Sequential successor to the per-transistor current models: one instance per circuit node.
- Sums N signed channel currents, integrates them onto a W-bit node voltage with capacitance scaling and rail clamping, and derives a hysteretic logic level.
- Flags when the node has settled, so the simulation controller can stop relaxation iterations.
- Sits between the transistor/pullup/pad current outputs and the gate inputs of downstream transistors.

Parameters:
- W, 16, voltage/current word width (signed two's complement).
- N, 4, number of current input channels (N >= 1).
- SHIFT, 2, capacitance scaling: integrated step = current sum arithmetically shifted right by SHIFT.
- VHI, 16384, upper rail clamp (signed W-bit).
- VLO, -16384, lower rail clamp (signed W-bit); VLO < VHI.
- TH_HI, 4096, logic rising threshold; TH_LO <= TH_HI.
- TH_LO, -4096, logic falling threshold.
- EPS, 0, settle tolerance on |per-cycle voltage change|.
- SETTLE_CYCLES, 8, consecutive quiet cycles required before settled asserts (>= 1).
- INIT_LOGIC, 0, reset state: 0 -> v=VLO, logic_o=0; 1 -> v=VHI, logic_o=1.

Ports:
- eclk  in  1  simulation clock.
- erst_n  in  1  asynchronous active-low reset.
- en  in  1  integrate enable; 0 holds all state.
- load  in  1  preset node voltage this cycle.
- load_v  in  W  preset value, signed.
- i_flat  in  N*W  channel currents; channel k at bits [k*W +: W], signed, positive = charging.
- v  out  W  node voltage, registered, signed.
- logic_o  out  1  hysteretic logic level, registered.
- settled  out  1  node settled, registered.
- sat_flag  out  1  last update was clamped to a rail, registered.

Behaviour:
- Reset (erst_n=0, asynchronous, any time, including mid-integration):
  - v = INIT_LOGIC ? VHI : VLO; logic_o = INIT_LOGIC.
  - settled = 0; sat_flag = 0; quiet counter = 0.
- Sum: sign-extend each channel to W+clog2(N)+1 bits and add all channels. No overflow is possible at this width.
- Step: step = sum >>> SHIFT. Arithmetic shift, floor toward -inf (-1 >>> 2 = -1).
- Raw next value: vn = v + step, computed at 2 bits wider than the sum.
- Clamp: v_next = min(max(vn, VLO), VHI). sat = (vn != v_next).
- Load: load=1 has priority over en.
  - v_next = clamp(load_v); sat = (load_v out of range).
  - Quiet counter cleared to 0; settled = 0 next edge.
- Hold: en=0 and load=0 -> all registers hold, including counter, settled and sat_flag.
- Latency: every update is registered. Inputs sampled at edge t appear on v, logic_o and sat_flag after edge t.
- Hysteresis, evaluated on v_next:
  - v_next > TH_HI -> logic_o = 1.
  - v_next < TH_LO -> logic_o = 0.
  - otherwise logic_o holds its previous value.
  - Applies on load updates too.
- Settle detect, integrate cycles only (en=1, load=0):
  - If |v_next - v| <= EPS, the counter increments and saturates at SETTLE_CYCLES; otherwise it clears to 0.
  - settled register = (counter_next == SETTLE_CYCLES).
  - A clamped step that produces no change counts as quiet.
- sat_flag is updated on every en=1 or load=1 cycle with that cycle's sat value.
- Simultaneous events: load and en both 1 -> treated as load only; currents ignored that cycle.

Test Plan:
- Reset, defaults: erst_n=0 for 3 cycles with en=1, i0=1000 -> v=-16384, logic_o=0, settled=0, sat_flag=0. Release erst_n -> first update gives v=-16134.
- Integration and floor:
  - load_v=0, then en=1, i0=400, others 0 -> v = 100, 200, 300 on successive edges.
  - i0=-1 -> v decrements by exactly 1 per edge.
  - i0=-400, i1=400 -> v holds.
- Saturation: load_v=16300, then i0=1000 -> v=16384, sat_flag=1. Next cycle i0=0 -> v=16384, sat_flag=0.
- Hysteresis:
  - load_v=0 -> logic_o=0.
  - i0=4000 -> v=1000, 2000, 3000, 4000 with logic_o=0; next edge v=5000 with logic_o=1.
  - i0=-4000 back down: logic_o stays 1 through v=0 and v=-4000; clears at v=-5000.
- Settling:
  - load_v=0, then en=1, all currents 0 -> settled rises on the 8th integrate edge.
  - i0=4 -> settled=0 on the next edge.
  - en=0 for 5 cycles -> settled and v unchanged.
- Async reset mid-operation: integrating at v=3000 with logic_o=1, drop erst_n between edges -> v=-16384 and logic_o=0 immediately, without waiting for eclk.
